// File: rtl/pulse_pattern_generator.sv
// rtl/pulse_pattern_generator.sv - serial pulse pattern generator with per-bit divider and one-shot/repeat modes
module pulse_pattern_generator #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH),
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [LEN_W-1:0] length_in,
  input  logic [DIV_W-1:0] divide_in,
  input  logic             oneshot_in,
  input  logic             load_flag,
  input  logic             start,
  input  logic             stop,
  output logic             o,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_index
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAX_IDX = WIDTH - 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pat, pat_nx;
  logic [LEN_W-1:0] len, len_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic             oneshot, oneshot_nx;
  logic [LEN_W-1:0] idx, idx_nx;
  logic [DIV_W-1:0] divcnt, divcnt_nx;
  logic             o_nx;
  logic             done_nx;
  logic [LEN_W-1:0] len_sat;

  // Bit select through a shift so the index width may exceed what WIDTH strictly needs.
  function automatic logic pick(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
    logic [WIDTH-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // Lengths past the top of the pattern register clamp to the MSB.
  assign len_sat   = (32'(length_in) > MAX_IDX) ? LEN_W'(MAX_IDX) : length_in;
  assign bit_index = idx;

  // State, held config, counters and the registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pat     <= '0;
      len     <= '0;
      div     <= '0;
      oneshot <= 1'b0;
      idx     <= '0;
      divcnt  <= '0;
      o       <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      pat     <= pat_nx;
      len     <= len_nx;
      div     <= div_nx;
      oneshot <= oneshot_nx;
      idx     <= idx_nx;
      divcnt  <= divcnt_nx;
      o       <= o_nx;
      done    <= done_nx;
    end
  end

  // Next state and datapath: load beats stop beats start; otherwise RUN steps the divider and bit index.
  always_comb begin
    state_nx   = state;
    pat_nx     = pat;
    len_nx     = len;
    div_nx     = div;
    oneshot_nx = oneshot;
    idx_nx     = idx;
    divcnt_nx  = divcnt;
    o_nx       = o;
    done_nx    = 1'b0;
    if (load_flag) begin
      pat_nx     = pattern_in;
      len_nx     = len_sat;
      div_nx     = divide_in;
      oneshot_nx = oneshot_in;
      idx_nx     = len_sat;
      divcnt_nx  = '0;
      o_nx       = pick(pattern_in, len_sat);
      state_nx   = RUN;
    end else if (stop) begin
      state_nx = IDLE;
      o_nx     = 1'b0;
      idx_nx   = '0;
    end else if (start) begin
      idx_nx    = len;
      divcnt_nx = '0;
      o_nx      = pick(pat, len);
      state_nx  = RUN;
    end else if (state == RUN) begin
      if (divcnt < div) begin
        divcnt_nx = divcnt + DIV_W'(1);
      end else begin
        divcnt_nx = '0;
        if (idx != '0) begin
          idx_nx = idx - LEN_W'(1);
          o_nx   = pick(pat, idx - LEN_W'(1));
        end else if (!oneshot) begin
          // Wrap straight back to the first bit with no gap cycle.
          idx_nx = len;
          o_nx   = pick(pat, len);
        end else begin
          o_nx     = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
    end
  end

  // Busy simply reflects the RUN state.
  always_comb begin
    busy = (state == RUN);
  end

endmodule

// File: tb/tb_pulse_pattern_generator.sv
// tb/tb_pulse_pattern_generator.sv - scoreboard bench for pulse_pattern_generator
module tb_pulse_pattern_generator;

  localparam int WIDTH = 16;
  localparam int LW    = 5;
  localparam int DW    = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] pattern_in = '0;
  logic [LW-1:0]    length_in = '0;
  logic [DW-1:0]    divide_in = '0;
  logic             oneshot_in = 1'b0;
  logic             load_flag = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             o;
  logic             busy;
  logic             done;
  logic [LW-1:0]    bit_index;

  typedef struct packed {
    logic          o;
    logic          busy;
    logic          done;
    logic [LW-1:0] idx;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  pulse_pattern_generator #(.WIDTH(WIDTH), .LEN_W(LW), .DIV_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .pattern_in(pattern_in), .length_in(length_in),
    .divide_in(divide_in), .oneshot_in(oneshot_in), .load_flag(load_flag), .start(start),
    .stop(stop), .o(o), .busy(busy), .done(done), .bit_index(bit_index)
  );

  always #5 clock = ~clock;

  task automatic compare(input string tag, input obs_t e);
    obs_t a;
    a = {o, busy, done, bit_index};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got o=%0b busy=%0b done=%0b idx=%0d expected o=%0b busy=%0b done=%0b idx=%0d",
               tag, a.o, a.busy, a.done, a.idx, e.o, e.busy, e.done, e.idx);
    end
  endtask

  task automatic cfg(input logic [WIDTH-1:0] p, input logic [LW-1:0] l, input logic [DW-1:0] d,
                     input logic os);
    pattern_in = p;
    length_in  = l;
    divide_in  = d;
    oneshot_in = os;
  endtask

  // One clock: apply controls, queue the outputs expected after the coming edge.
  task automatic cyc(input logic ld, input logic st, input logic sp, input logic eo, input logic eb,
                     input logic ed, input logic [LW-1:0] ei, input string tag);
    obs_t e;
    load_flag = ld;
    start     = st;
    stop      = sp;
    e = {eo, eb, ed, ei};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    @(negedge clock);
    load_flag = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a new output sample just after the edge.
  initial begin
    obs_t  e;
    string t;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        compare(t, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    compare("reset_hold", '0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, "reset_idle");

    // 0xAAAA, full length, one bit per clock, repeat
    cfg(16'hAAAA, 15, 0, 0);
    for (int i = 0; i < 64; i++)
      cyc(i == 0, 0, 0, (i % 2) == 0, 1, 0, 5'(15 - (i % 16)), "alt_repeat");
    cyc(0, 0, 1, 0, 0, 0, 0, "alt_stop");

    // 0xE000, divide by 3: 9 high, 39 low, period 48
    cfg(16'hE000, 15, 2, 0);
    for (int i = 0; i < 144; i++)
      cyc(i == 0, 0, 0, (i % 48) < 9, 1, 0, 5'(15 - ((i % 48) / 3)), "burst_div3");
    cyc(0, 0, 1, 0, 0, 0, 0, "burst_stop");

    // 0x0005 one-shot of length 4
    cfg(16'h0005, 3, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 3, "os_b3");
    cyc(0, 0, 0, 1, 1, 0, 2, "os_b2");
    cyc(0, 0, 0, 0, 1, 0, 1, "os_b1");
    cyc(0, 0, 0, 1, 1, 0, 0, "os_b0");
    cyc(0, 0, 0, 0, 0, 1, 0, "os_done");
    cyc(0, 0, 0, 0, 0, 0, 0, "os_after");

    // 0x00FF, len 7, div 1: stop at cycle 5, then restart with start
    cfg(16'h00FF, 7, 1, 0);
    for (int i = 0; i < 5; i++)
      cyc(i == 0, 0, 0, 1, 1, 0, 5'(7 - i / 2), "ff_run");
    cyc(0, 0, 1, 0, 0, 0, 0, "ff_stop");
    cyc(0, 0, 0, 0, 0, 0, 0, "ff_idle");
    for (int j = 0; j < 18; j++)
      cyc(j == 0, 0, 0, 1, 1, 0, 5'(7 - ((j / 2) % 8)), "ff_restart");
    cyc(0, 0, 1, 0, 0, 0, 0, "ff_stop2");

    // load + stop + start together while running: load wins
    cyc(0, 1, 0, 1, 1, 0, 7, "pri_start");
    cyc(0, 0, 0, 1, 1, 0, 7, "pri_run");
    cfg(16'h8001, 15, 0, 0);
    cyc(1, 1, 1, 1, 1, 0, 15, "pri_load");
    cyc(0, 0, 0, 0, 1, 0, 14, "pri_next");
    cyc(0, 0, 0, 0, 1, 0, 13, "pri_next2");
    cyc(0, 0, 1, 0, 0, 0, 0, "pri_stop");

    // one-shot ends on the same edge as a new load: no done, new pattern runs
    cfg(16'h0005, 3, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 3, "col_b3");
    cyc(0, 0, 0, 1, 1, 0, 2, "col_b2");
    cyc(0, 0, 0, 0, 1, 0, 1, "col_b1");
    cyc(0, 0, 0, 1, 1, 0, 0, "col_b0");
    cfg(16'h0002, 1, 0, 1);
    cyc(1, 0, 0, 1, 1, 0, 1, "col_load");
    cyc(0, 0, 0, 0, 1, 0, 0, "col_n0");
    cyc(0, 0, 0, 0, 0, 1, 0, "col_done");
    cyc(0, 0, 0, 0, 0, 0, 0, "col_after");

    // asynchronous reset between edges while running
    cfg(16'hAAAA, 15, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 15, "rst_run0");
    cyc(0, 0, 0, 0, 1, 0, 14, "rst_run1");
    cyc(0, 0, 0, 1, 1, 0, 13, "rst_run2");
    #2 reset_n = 1'b0;
    #1 compare("rst_async", '0);
    @(negedge clock);
    cyc(0, 0, 0, 0, 0, 0, 0, "rst_held");
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, "rst_released_idle");
    // reset cleared the held config: start runs an all-zero single-bit pattern
    cyc(0, 1, 0, 0, 1, 0, 0, "rst_cfg_start");
    cyc(0, 0, 0, 0, 1, 0, 0, "rst_cfg_run");
    cyc(0, 0, 1, 0, 0, 0, 0, "rst_cfg_stop");

    // length 20 saturates to 15; full-length one-shot of 0x8000
    cfg(16'h8000, 20, 0, 1);
    for (int i = 0; i <= 16; i++)
      cyc(i == 0, 0, 0, i == 0, i < 16, i == 16, (i < 16) ? 5'(15 - i) : 5'd0, "sat_len");

    // len 0 with maximum divider: one bit held for 256 clocks, then done
    cfg(16'h0001, 0, 8'hFF, 1);
    for (int i = 0; i <= 256; i++)
      cyc(i == 0, 0, 0, i < 256, i < 256, i == 256, 0, "maxdiv");
    cyc(0, 0, 0, 0, 0, 0, 0, "maxdiv_after");

    @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
